// File: rtl/sonar_ranging_scheduler.sv
// Round-robin HC-SR04 ranging scheduler: trigger, echo timing and inter-shot quiet gap.
// Optional SONAR_ECHO_FILT_EN adds a 4-sample glitch filter after the echo synchroniser.
module sonar_ranging_scheduler #(
  parameter int N_SENS      = 4,
  parameter int TRIG_CYC    = 1000,
  parameter int ECHO_TO_CYC = 3800000,
  parameter int GAP_CYC     = 6000000,
  parameter int CNT_W       = 23,
  localparam int ID_W       = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_SENS-1:0] sens_mask,
  input  logic [N_SENS-1:0] echo,
  output logic [N_SENS-1:0] trig,
  output logic              meas_valid,
  output logic [ID_W-1:0]   meas_id,
  output logic [CNT_W-1:0]  meas_cycles,
  output logic              meas_timeout,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_TO_CYC - 1);
  localparam logic [CNT_W-1:0] ECHO_TO   = CNT_W'(ECHO_TO_CYC);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  state_t              state_q;
  logic [ID_W-1:0]     cur_q, last_q, id_q;
  logic [CNT_W-1:0]    cnt_q, cycles_q;
  logic [N_SENS-1:0]   trig_q;
  logic                valid_q, timeout_q;
  logic [N_SENS-1:0]   echo_m_q, echo_s_q, echo_prv_q, echo_lvl;
  logic [ID_W-1:0]     sel_d;
  logic                go_d, echo_cur, echo_prv_cur;

  // First set mask bit strictly after 'from', wrapping; a lone bit selects itself again.
  function automatic logic [ID_W-1:0] pickNext(input logic [N_SENS-1:0] mask,
                                               input logic [ID_W-1:0] from);
    pickNext = from;
    for (int k = N_SENS; k >= 1; k--)
      for (int j = 0; j < N_SENS; j++)
        if (mask[j] && j == (int'(from) + k) % N_SENS) pickNext = ID_W'(j);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_m_q   <= '0;
      echo_s_q   <= '0;
      echo_prv_q <= '0;
    end else begin
      echo_m_q   <= echo;
      echo_s_q   <= echo_m_q;
      echo_prv_q <= echo_lvl;
    end
  end

`ifdef SONAR_ECHO_FILT_EN
  logic [N_SENS-1:0] h1_q, h2_q, h3_q, filt_q;

  // Output flips only once the current and three previous samples all agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q   <= '0;
      h2_q   <= '0;
      h3_q   <= '0;
      filt_q <= '0;
    end else begin
      h1_q   <= echo_s_q;
      h2_q   <= h1_q;
      h3_q   <= h2_q;
      filt_q <= (filt_q | (echo_s_q & h1_q & h2_q & h3_q)) & (echo_s_q | h1_q | h2_q | h3_q);
    end
  end

  assign echo_lvl = filt_q;
`else
  assign echo_lvl = echo_s_q;
`endif

  assign sel_d        = pickNext(sens_mask, last_q);
  assign go_d         = enable && (sens_mask != '0);
  assign echo_cur     = echo_lvl[cur_q];
  assign echo_prv_cur = echo_prv_q[cur_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      last_q    <= ID_W'(N_SENS - 1);
      cnt_q     <= '0;
      trig_q    <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_d) begin
            cur_q   <= sel_d;
            trig_q  <= N_SENS'(1) << sel_d;
            cnt_q   <= '0;
            state_q <= TRIG;
          end
        end
        TRIG: begin
          if (cnt_q == TRIG_LAST) begin
            trig_q  <= '0;
            cnt_q   <= '0;
            state_q <= WAIT_RISE;
          end else cnt_q <= cnt_q + 1'b1;
        end
        WAIT_RISE: begin
          // The rise cycle is itself the first high cycle, hence the count starts at 1.
          if (echo_cur && !echo_prv_cur) begin
            cnt_q   <= CNT_W'(1);
            state_q <= MEASURE;
          end else if (cnt_q == ECHO_LAST) begin
            valid_q   <= 1'b1;
            id_q      <= cur_q;
            last_q    <= cur_q;
            cycles_q  <= ECHO_TO;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= GAP;
          end else cnt_q <= cnt_q + 1'b1;
        end
        MEASURE: begin
          if (!echo_cur) begin
            valid_q   <= 1'b1;
            id_q      <= cur_q;
            last_q    <= cur_q;
            cycles_q  <= cnt_q;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= GAP;
          end else if (cnt_q == ECHO_LAST) begin
            valid_q   <= 1'b1;
            id_q      <= cur_q;
            last_q    <= cur_q;
            cycles_q  <= ECHO_TO;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= GAP;
          end else cnt_q <= cnt_q + 1'b1;
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (go_d) begin
              cur_q   <= sel_d;
              trig_q  <= N_SENS'(1) << sel_d;
              state_q <= TRIG;
            end else state_q <= IDLE;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trig         = trig_q;
  assign meas_valid   = valid_q;
  assign meas_id      = id_q;
  assign meas_cycles  = cycles_q;
  assign meas_timeout = timeout_q;
  assign busy         = (state_q != IDLE);

endmodule
